// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_HALT
  } state_t;

  localparam int INSTR_WIDTH = 9;
  localparam int OPCODE_MSB  = 8;
  localparam int OPCODE_LSB  = 5;

  localparam logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE = 4'b1111;

  function automatic logic is_halt(input logic [OPCODE_MSB-OPCODE_LSB:0] opcode);
    return opcode == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_sequencer_program_counter.sv
// Program counter: holds the fetch address, advances by one (wrapping)
// or loads a branch target when an instruction completes.
module program_counter #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                advance,
  input  logic                branch,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc
);

  // PC update on instruction completion; natural overflow gives the wrap to 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (advance) begin
      pc <= branch ? target : pc + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute sequencer for a 9-bit instruction machine.
// Optional feature: define MEM_TIMEOUT_EN to halt with a sticky fault when
// memory does not acknowledge a fetch within TIMEOUT_CYCLES cycles.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | memory read outstanding at pc
// DECODE  | instruction register valid; halt check, execute kick-off
// EXECUTE | waiting for exec_done, then pc update
// HALT    | stopped until reset
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH       = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC       = '0,
  parameter int                  TIMEOUT_CYCLES = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic                   mem_req,
  output logic [PC_WIDTH-1:0]    mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  output logic                   ir_load,
  output logic [INSTR_WIDTH-1:0] ir_data,
  input  logic [INSTR_WIDTH-1:0] ir_q,
  output logic                   exec_start,
  input  logic                   exec_done,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   busy,
  output logic                   halted,
  output logic                   fault
);

  state_t              state;
  logic                mem_req_q;
  logic                busy_q;
  logic                halted_q;
  logic                halt_instr;
  logic                pc_advance;
  logic                timeout_hit;
  logic [PC_WIDTH-1:0] pc;
  logic                unused_ir_bits;

  // Only the opcode field of the instruction matters to sequencing.
  assign unused_ir_bits = ^ir_q[OPCODE_LSB-1:0];
  assign halt_instr     = is_halt(ir_q[OPCODE_MSB:OPCODE_LSB]);

  assign mem_req    = mem_req_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign mem_addr   = pc;
  assign ir_data    = mem_data;
  assign ir_load    = (state == ST_FETCH) && mem_ack;
  assign exec_start = (state == ST_DECODE) && !halt_instr;
  assign pc_advance = (state == ST_EXECUTE) && exec_done;

  program_counter #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock   (clock),
    .reset   (reset),
    .advance (pc_advance),
    .branch  (branch_taken),
    .target  (branch_target),
    .pc      (pc)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] timeout_cnt;
  logic          fault_q;

  assign timeout_hit = (state == ST_FETCH) && !mem_ack &&
                       (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign fault       = fault_q;

  // Count unacknowledged fetch cycles; any ack or leaving fetch clears it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_cnt <= '0;
      fault_q     <= 1'b0;
    end else begin
      if (state == ST_FETCH && !mem_ack && !timeout_hit) begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end else begin
        timeout_cnt <= '0;
      end
      if (timeout_hit) begin
        fault_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
  assign fault          = 1'b0;
`endif

  // Sequencing FSM; status outputs are registered alongside the state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FETCH;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (mem_ack) begin
            state     <= ST_DECODE;
            mem_req_q <= 1'b0;
          end else if (timeout_hit) begin
            state     <= ST_HALT;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (halt_instr) begin
            state    <= ST_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if (exec_done) begin
            state     <= ST_FETCH;
            mem_req_q <= 1'b1;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state     <= ST_IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameters SHALL be: PC_WIDTH, 8, program-counter/address width; RESET_PC, 0, PC value after reset; TIMEOUT_CYCLES, 16, memory-ack timeout limit (used only with MEM_TIMEOUT_EN).
REQ-002 CLOCK  input  1  single clock; all state changes on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 START  input  1  begin fetching from PC; sampled only in IDLE.
REQ-005 MEM_REQ  output  1  instruction-memory read request.
REQ-006 MEM_ADDR  output  PC_WIDTH  read address; equals PC.
REQ-007 MEM_ACK  input  1  read data valid this cycle.
REQ-008 MEM_DATA  input  9  instruction word from memory.
REQ-009 IR_LOAD  output  1  load strobe to the 9-bit instruction register.
REQ-010 IR_DATA  output  9  instruction register data input; equals MEM_DATA.
REQ-011 IR_Q  input  9  instruction register output; opcode field is IR_Q[8:5].
REQ-012 EXEC_START  output  1  one-cycle execute-start pulse.
REQ-013 EXEC_DONE  input  1  execution complete; sampled only in EXECUTE.
REQ-014 BRANCH_TAKEN  input  1  qualifies EXEC_DONE; next PC = BRANCH_TARGET.
REQ-015 BRANCH_TARGET  input  PC_WIDTH  branch destination.
REQ-016 BUSY  output  1  high in FETCH, DECODE, EXECUTE.
REQ-017 HALTED  output  1  high in HALT.
REQ-018 FAULT  output  1  sticky memory-timeout flag.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, DECODE, EXECUTE, HALT.
REQ-020 IDLE: all strobes low; START=1 -> FETCH next cycle.
REQ-021 FETCH: MEM_REQ=1, MEM_ADDR=PC held stable until MEM_ACK.
REQ-022 FETCH with MEM_ACK=1: IR_LOAD=1 combinationally in the same cycle; next state DECODE.
REQ-023 IR_LOAD SHALL never assert outside FETCH, or in FETCH without MEM_ACK.
REQ-024 DECODE: IR_Q[8:5]=4'b1111 (halt) -> HALT with no EXEC_START; otherwise EXEC_START=1 for exactly this cycle, next state EXECUTE.
REQ-025 EXECUTE: wait for EXEC_DONE; on EXEC_DONE, PC <= BRANCH_TAKEN ? BRANCH_TARGET : PC+1, next state FETCH.
REQ-026 PC+1 SHALL wrap modulo 2^PC_WIDTH (max -> 0).
REQ-027 EXEC_DONE or BRANCH_TAKEN asserted outside EXECUTE SHALL be ignored, including during the DECODE cycle.
REQ-028 Minimum instruction period SHALL be 3 cycles (ACK in first FETCH cycle, EXEC_DONE in first EXECUTE cycle).
REQ-029 HALT: HALTED=1, all strobes low, PC frozen; exit only by RESET; START ignored.
REQ-030 START in any state other than IDLE SHALL be ignored.

Reset
REQ-031 RESET SHALL asynchronously force state IDLE, PC=RESET_PC, FAULT=0, timeout counter=0.
REQ-032 During and after reset MEM_REQ, IR_LOAD, EXEC_START, BUSY, HALTED SHALL be 0; MEM_ADDR=RESET_PC.
REQ-033 Reset mid-fetch or mid-execute SHALL abandon the operation with no IR_LOAD or PC update.

Configuration
REQ-034 Macro MEM_TIMEOUT_EN defined: counter increments each FETCH cycle without MEM_ACK, clears on ACK or leaving FETCH; reaching TIMEOUT_CYCLES -> HALT with FAULT=1 until reset.
REQ-035 MEM_TIMEOUT_EN undefined: FETCH waits indefinitely; FAULT tied 0; no counter logic.

Structure
REQ-036 Package fetch_sequencer_pkg SHALL hold the state enum, HALT_OPCODE (4'b1111), and opcode field msb/lsb constants.
REQ-037 PC register, increment/wrap, and branch load SHALL be one sub-module, program_counter.

Verification
REQ-038 Reset then START with MEM_ACK in the first FETCH cycle, MEM_DATA=9'b0_1100_0010, EXEC_DONE next EXECUTE cycle -> IR_LOAD pulse, EXEC_START 1 cycle later, PC 0->1, 3-cycle period.
REQ-039 MEM_ACK delayed 4 cycles -> MEM_REQ high 5 cycles with MEM_ADDR stable; IR_LOAD only in the ACK cycle.
REQ-040 EXEC_DONE with BRANCH_TAKEN=1, BRANCH_TARGET=8'h40 -> next MEM_ADDR=8'h40; PC=8'hFF with no branch -> next MEM_ADDR=8'h00.
REQ-041 Fetch of 9'b1_1110_0000 -> HALTED=1, no EXEC_START, START pulses ignored, RESET returns to IDLE.
REQ-042 RESET asserted in EXECUTE -> outputs clear immediately, PC=RESET_PC; EXEC_DONE pulse during DECODE ignored.
REQ-043 With MEM_TIMEOUT_EN, no ACK for 16 FETCH cycles -> FAULT=1, HALTED=1; without the macro, same stimulus stays in FETCH.
